regs_wb: RTL and testbench
==========================

Name: regs_wb

Overview:
- Writeback sequencer that drives the single write port of the `regs` register file (`i_we`, `i_addr_wr`, `i_dat_wr`).
- Merges two result sources:
  - the fixed-latency ALU stream, which has no backpressure and highest priority;
  - the variable-latency load-return stream, which uses a valid/ready handshake and is buffered in an internal FIFO.
- Also reports whether a queued load targets a queried register, for the hazard logic.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, at least 2.
- XLEN, 32, data width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_alu_valid  in  1  ALU result valid this cycle; always accepted
- i_alu_rd  in  5  ALU destination register
- i_alu_dat  in  XLEN  ALU result
- i_ld_valid  in  1  load result valid
- o_ld_ready  out  1  load input can accept
- i_ld_rd  in  5  load destination register
- i_ld_dat  in  XLEN  load data
- i_chk_addr  in  5  register to test for a pending load
- o_chk_pending  out  1  a queued load targets i_chk_addr (combinational)
- o_we  out  1  register-file write enable
- o_addr_wr  out  5  register-file write address
- o_dat_wr  out  XLEN  register-file write data
- o_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, i_rst_n=0):
  - o_we=0, o_addr_wr=0, o_dat_wr=0.
  - FIFO read/write pointers and count are 0, so o_count=0, o_ld_ready=1, o_chk_pending=0.
  - Reset asserted mid-operation discards all queued loads immediately.
- Load accept: a load transfers on a rising edge when i_ld_valid=1 and o_ld_ready=1.
- o_ld_ready = (count < DEPTH), computed from the registered count only. No same-cycle dequeue credit: when full, ready stays 0 even in a cycle that drains an entry.
- Output select, evaluated each cycle, with the result registered on the edge:
  1. i_alu_valid=1: output takes the ALU result; FIFO is not drained.
  2. else FIFO non-empty: output takes the FIFO head; head pops.
  3. else (bypass rules below): output idle, o_we=0.
- x0 rule: if the selected rd=0, o_we=0.
  - The entry is still consumed (ALU result dropped, FIFO popped).
  - o_addr_wr and o_dat_wr still update to the selected values.
  - Loads to x0 are still queued and still count toward occupancy.
- Latency:
  - ALU accepted in cycle N → o_we=1 in cycle N+1.
  - Queued load → written no earlier than 1 cycle after the cycle it is at the head with the ALU idle.
- Simultaneous events:
  - A load accept and a pop in the same cycle leaves the count unchanged.
  - Accept without pop: count +1. Pop without accept: count −1.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Ordering:
  - Loads write in arrival order.
  - ALU vs load ordering to the same rd is enforced upstream: issue stalls while o_chk_pending=1 for rd.
- o_chk_pending is the OR over valid FIFO entries of (entry.rd == i_chk_addr) && (i_chk_addr != 0).
  - With bypass enabled, it also includes an in-flight bypass load in the input stage.
- o_we is a registered single-cycle pulse per write. There is no hold; back-to-back writes on consecutive cycles are allowed.

Optional Feature:
- Macro: REGS_WB_BYPASS_EN.
- Defined:
  - When i_alu_valid=0, the FIFO is empty and a load transfers, the load goes straight to the output register without entering the FIFO.
  - Latency is accept at N → o_we at N+1.
  - Count is unchanged by a bypassed load.
- Undefined:
  - Every load enqueues.
  - Minimum latency is accept at N → o_we at N+2.
- The x0 and reset rules are identical in both builds.

Test Plan:
- Reset then ALU-only: ALU writes rd=5 dat=0x0005_5555 at N → o_we=1, o_addr_wr=5, o_dat_wr=0x0005_5555 at N+1. Then ALU rd=0 → o_we=0 the next cycle.
- Fill and stall: hold i_alu_valid=1 while presenting 5 loads (rd=1..5) with DEPTH=4.
  - o_ld_ready=0 after 4 accepts; o_count=4.
  - Release ALU → loads rd=1..4 written on 4 consecutive cycles in order.
  - Fifth load is accepted after ready returns to 1.
- Priority collision: FIFO holds rd=7. ALU rd=3 asserted the same cycle → rd=3 written first, rd=7 written the cycle after.
- Bypass latency: empty FIFO, ALU idle, load rd=9 dat=0xDEAD_BEEF accepted at N.
  - REGS_WB_BYPASS_EN defined → o_we at N+1.
  - Undefined → o_we at N+2.
- Pending check: queue loads rd=4 and rd=0.
  - i_chk_addr=4 → o_chk_pending=1; i_chk_addr=0 → 0.
  - After drain: i_chk_addr=4 → 0; the x0 load produces no o_we pulse.
- Mid-operation reset: with 3 entries queued, pulse i_rst_n=0 asynchronously between edges.
  - o_we=0, o_count=0 and o_ld_ready=1 immediately.
  - No queued write appears after reset is released.

Source files
------------

// File: rtl/regs_wb.sv
// regs_wb: writeback sequencer for the single write port of the regs file.
// Merges the ALU stream (highest priority, no backpressure) with load returns
// buffered in a DEPTH-entry FIFO. Optional macro REGS_WB_BYPASS_EN lets a load
// skip the FIFO when the FIFO is empty and the ALU is idle.
module regs_wb #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_alu_valid,
  input  logic [4:0]               i_alu_rd,
  input  logic [XLEN-1:0]          i_alu_dat,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [4:0]               i_ld_rd,
  input  logic [XLEN-1:0]          i_ld_dat,
  input  logic [4:0]               i_chk_addr,
  output logic                     o_chk_pending,
  output logic                     o_we,
  output logic [4:0]               o_addr_wr,
  output logic [XLEN-1:0]          o_dat_wr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      r_mem_rd  [DEPTH];
  logic [XLEN-1:0] r_mem_dat [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            r_we;
  logic [4:0]      r_addr;
  logic [XLEN-1:0] r_dat;

  logic            w_empty;
  logic            w_accept;
  logic            w_pop;
  logic            w_push;
  logic            w_bypass;
  logic            w_sel_valid;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_dat;
  logic            w_match;
  logic [PW-1:0]   w_off;

  assign o_ld_ready = (r_count < CW'(DEPTH));
  assign o_count    = r_count;
  assign o_we       = r_we;
  assign o_addr_wr  = r_addr;
  assign o_dat_wr   = r_dat;

  // Source select: ALU first, then FIFO head, then (optionally) the incoming load
  always_comb begin
    w_empty     = (r_count == '0);
    w_accept    = i_ld_valid && o_ld_ready;
    w_pop       = !i_alu_valid && !w_empty;
`ifdef REGS_WB_BYPASS_EN
    w_bypass    = !i_alu_valid && w_empty && w_accept;
`else
    w_bypass    = 1'b0;
`endif
    w_push      = w_accept && !w_bypass;
    w_sel_valid = i_alu_valid || w_pop || w_bypass;
    w_sel_rd    = '0;
    w_sel_dat   = '0;
    if (i_alu_valid) begin
      w_sel_rd  = i_alu_rd;
      w_sel_dat = i_alu_dat;
    end else if (w_pop) begin
      w_sel_rd  = r_mem_rd[r_rptr];
      w_sel_dat = r_mem_dat[r_rptr];
    end else if (w_bypass) begin
      w_sel_rd  = i_ld_rd;
      w_sel_dat = i_ld_dat;
    end
  end

  // Pending-load lookup: an entry is live when its distance from the read pointer is below count
  always_comb begin
    w_match = 1'b0;
    w_off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rptr;
      if (({1'b0, w_off} < r_count) && (r_mem_rd[i] == i_chk_addr))
        w_match = 1'b1;
    end
`ifdef REGS_WB_BYPASS_EN
    if (w_bypass && (i_ld_rd == i_chk_addr))
      w_match = 1'b1;
`endif
    o_chk_pending = w_match && (i_chk_addr != '0);
  end

  // FIFO storage: data only, no reset needed since validity comes from count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]  <= i_ld_rd;
      r_mem_dat[r_wptr] <= i_ld_dat;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-port register: x0 targets consume the entry but suppress the enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_dat  <= '0;
    end else if (w_sel_valid) begin
      r_we   <= (w_sel_rd != '0);
      r_addr <= w_sel_rd;
      r_dat  <= w_sel_dat;
    end else begin
      r_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regs_wb.sv
// Self-checking bench for regs_wb (DEPTH=4, XLEN=32). Expected register-file
// writes are queued by the stimulus; a monitor pops one per o_we pulse.
module tb_regs_wb;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_dat;
  logic        i_ld_valid;
  logic        o_ld_ready;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_dat;
  logic [4:0]  i_chk_addr;
  logic        o_chk_pending;
  logic        o_we;
  logic [4:0]  o_addr_wr;
  logic [31:0] o_dat_wr;
  logic [2:0]  o_count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  regs_wb #(.DEPTH(4), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_dat(i_alu_dat),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd), .i_ld_dat(i_ld_dat),
    .i_chk_addr(i_chk_addr), .o_chk_pending(o_chk_pending),
    .o_we(o_we), .o_addr_wr(o_addr_wr), .o_dat_wr(o_dat_wr), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] dat);
    exp_q.push_back('{rd: rd, dat: dat});
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation
  always @(posedge i_clk) begin
    #2;
    if (i_rst_n && o_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {27'd0, o_addr_wr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_addr", {27'd0, o_addr_wr}, {27'd0, e.rd});
        check("sb_dat", o_dat_wr, e.dat);
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_dat = '0;
    i_ld_valid = 1'b0; i_ld_rd = '0; i_ld_dat = '0; i_chk_addr = '0;
    #3;
    check("rst_we", {31'd0, o_we}, 32'd0);
    check("rst_addr", {27'd0, o_addr_wr}, 32'd0);
    check("rst_dat", o_dat_wr, 32'd0);
    check("rst_count", {29'd0, o_count}, 32'd0);
    check("rst_ready", {31'd0, o_ld_ready}, 32'd1);
    check("rst_pending", {31'd0, o_chk_pending}, 32'd0);
    cyc(); cyc();
    i_rst_n = 1'b1;
    cyc();

    // ALU only, then ALU to x0
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_dat = 32'h0005_5555;
    expect_wr(5'd5, 32'h0005_5555);
    cyc();
    check("alu_we", {31'd0, o_we}, 32'd1);
    check("alu_addr", {27'd0, o_addr_wr}, 32'd5);
    i_alu_rd = 5'd0; i_alu_dat = 32'h0000_1234;
    cyc();
    check("alu_x0_we", {31'd0, o_we}, 32'd0);
    check("alu_x0_addr", {27'd0, o_addr_wr}, 32'd0);
    check("alu_x0_dat", o_dat_wr, 32'h0000_1234);
    i_alu_valid = 1'b0;
    cyc();
    check("idle_we", {31'd0, o_we}, 32'd0);

    // Fill and stall: ALU busy while loads 1..4 fill the FIFO, load 5 waits
    for (int i = 1; i <= 4; i++) begin
      i_alu_valid = 1'b1; i_alu_rd = 5'(20 + i); i_alu_dat = 32'hA000_0000 + i;
      expect_wr(5'(20 + i), 32'hA000_0000 + i);
      i_ld_valid = 1'b1; i_ld_rd = 5'(i); i_ld_dat = 32'h100 + i;
      cyc();
    end
    check("fill_count", {29'd0, o_count}, 32'd4);
    check("fill_ready", {31'd0, o_ld_ready}, 32'd0);
    i_alu_rd = 5'd25; i_alu_dat = 32'hA000_0005;
    expect_wr(5'd25, 32'hA000_0005);
    i_ld_rd = 5'd5; i_ld_dat = 32'h105;
    cyc();
    check("stall_count", {29'd0, o_count}, 32'd4);
    check("stall_ready", {31'd0, o_ld_ready}, 32'd0);
    for (int i = 1; i <= 5; i++) expect_wr(5'(i), 32'h100 + i);
    i_alu_valid = 1'b0;
    cyc();
    check("drain1_we", {31'd0, o_we}, 32'd1);
    check("drain1_addr", {27'd0, o_addr_wr}, 32'd1);
    check("drain1_count", {29'd0, o_count}, 32'd3);
    check("drain1_ready", {31'd0, o_ld_ready}, 32'd1);
    cyc();
    check("drain2_addr", {27'd0, o_addr_wr}, 32'd2);
    check("drain2_count", {29'd0, o_count}, 32'd3);
    i_ld_valid = 1'b0;
    cyc();
    check("drain3_addr", {27'd0, o_addr_wr}, 32'd3);
    cyc();
    check("drain4_we", {31'd0, o_we}, 32'd1);
    check("drain4_addr", {27'd0, o_addr_wr}, 32'd4);
    cyc();
    check("drain5_addr", {27'd0, o_addr_wr}, 32'd5);
    check("drain5_count", {29'd0, o_count}, 32'd0);
    cyc();
    check("drained_we", {31'd0, o_we}, 32'd0);

    // Priority collision: rd=7 queued, ALU rd=3 wins the next cycle
    i_alu_valid = 1'b1; i_alu_rd = 5'd2; i_alu_dat = 32'h222;
    i_ld_valid = 1'b1; i_ld_rd = 5'd7; i_ld_dat = 32'h777;
    expect_wr(5'd2, 32'h222);
    cyc();
    check("prio_count", {29'd0, o_count}, 32'd1);
    i_ld_valid = 1'b0; i_alu_rd = 5'd3; i_alu_dat = 32'h333;
    expect_wr(5'd3, 32'h333);
    expect_wr(5'd7, 32'h777);
    cyc();
    check("prio_alu_addr", {27'd0, o_addr_wr}, 32'd3);
    check("prio_hold_count", {29'd0, o_count}, 32'd1);
    i_alu_valid = 1'b0;
    cyc();
    check("prio_ld_we", {31'd0, o_we}, 32'd1);
    check("prio_ld_addr", {27'd0, o_addr_wr}, 32'd7);
    cyc();

    // Load latency from an empty FIFO with the ALU idle
    i_ld_valid = 1'b1; i_ld_rd = 5'd9; i_ld_dat = 32'hDEAD_BEEF;
    expect_wr(5'd9, 32'hDEAD_BEEF);
    cyc();
    i_ld_valid = 1'b0;
`ifdef REGS_WB_BYPASS_EN
    check("byp_n1_we", {31'd0, o_we}, 32'd1);
    check("byp_n1_addr", {27'd0, o_addr_wr}, 32'd9);
    check("byp_count", {29'd0, o_count}, 32'd0);
    cyc();
    check("byp_n2_we", {31'd0, o_we}, 32'd0);
`else
    check("nobyp_n1_we", {31'd0, o_we}, 32'd0);
    check("nobyp_count", {29'd0, o_count}, 32'd1);
    cyc();
    check("nobyp_n2_we", {31'd0, o_we}, 32'd1);
    check("nobyp_n2_addr", {27'd0, o_addr_wr}, 32'd9);
    check("nobyp_n2_dat", o_dat_wr, 32'hDEAD_BEEF);
`endif
    cyc();

    // Pending check: queue rd=4 and rd=0 behind ALU traffic
    i_alu_valid = 1'b1; i_alu_rd = 5'd11; i_alu_dat = 32'h1111;
    i_ld_valid = 1'b1; i_ld_rd = 5'd4; i_ld_dat = 32'h444;
    expect_wr(5'd11, 32'h1111);
    cyc();
    i_alu_rd = 5'd12; i_alu_dat = 32'h1212;
    i_ld_rd = 5'd0; i_ld_dat = 32'h0;
    expect_wr(5'd12, 32'h1212);
    cyc();
    i_alu_valid = 1'b0; i_ld_valid = 1'b0;
    check("pend_count", {29'd0, o_count}, 32'd2);
    i_chk_addr = 5'd4; #1;
    check("pend_rd4", {31'd0, o_chk_pending}, 32'd1);
    i_chk_addr = 5'd0; #1;
    check("pend_rd0", {31'd0, o_chk_pending}, 32'd0);
    i_chk_addr = 5'd12; #1;
    check("pend_rd12", {31'd0, o_chk_pending}, 32'd0);
    i_chk_addr = 5'd4;
    expect_wr(5'd4, 32'h444);
    cyc();
    check("pend_pop_addr", {27'd0, o_addr_wr}, 32'd4);
    check("pend_after_rd4", {31'd0, o_chk_pending}, 32'd0);
    cyc();
    check("pend_x0_we", {31'd0, o_we}, 32'd0);
    check("pend_x0_addr", {27'd0, o_addr_wr}, 32'd0);
    check("pend_x0_count", {29'd0, o_count}, 32'd0);

    // Mid-operation reset with three loads queued
    for (int i = 0; i < 3; i++) begin
      i_alu_valid = 1'b1; i_alu_rd = 5'(14 + i); i_alu_dat = 32'hC000_0000 + i;
      expect_wr(5'(14 + i), 32'hC000_0000 + i);
      i_ld_valid = 1'b1; i_ld_rd = 5'(1 + i); i_ld_dat = 32'h31 + i;
      cyc();
    end
    i_alu_valid = 1'b0; i_ld_valid = 1'b0;
    check("mrst_pre_count", {29'd0, o_count}, 32'd3);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mrst_we", {31'd0, o_we}, 32'd0);
    check("mrst_count", {29'd0, o_count}, 32'd0);
    check("mrst_ready", {31'd0, o_ld_ready}, 32'd1);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b1;
    repeat (6) cyc();
    check("mrst_post_count", {29'd0, o_count}, 32'd0);
    check("sb_all_consumed", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
